pio_edge_in: RTL and testbench
==============================

Name: pio_edge_in

Overview:
- Parametrised successor to the single-bit Avalon-MM input PIO used for FPGA/HPS acknowledge lines.
- Generalised to WIDTH input bits.
- Adds a configurable input synchroniser, per-bit edge capture, an interrupt mask and a registered level/edge IRQ.
- Sits as an Avalon-MM slave (s1) on the lightweight HPS bridge inside Computer_System.
- Read latency is fixed at 1 cycle.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, flip-flop stages on in_port before use (0 = no synchroniser, 0..3).
- EDGE_TYPE, 0, edge type captured: 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 1, interrupt source: 0 none (irq tied 0), 1 edge (edgecapture & mask), 2 level (data & mask).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data; only [WIDTH-1:0] used.
- in_port  in  WIDTH  external inputs, asynchronous to clk when SYNC_STAGES>0.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  registered interrupt request, active-high.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: readdata=0, irq=0, irqmask=0, edgecapture=0, all synchroniser stages=0, previous-sample register d_prev=0.
- Synchroniser:
  - data_in = in_port delayed by SYNC_STAGES cycles.
  - d_prev = data_in delayed by 1 cycle.
- Edge detect per bit:
  - rise = data_in & ~d_prev; fall = ~data_in & d_prev.
  - The EDGE_TYPE selection (rise, fall or rise|fall) is the edge pulse.
- Edge capture:
  - edgecapture[i] is sticky; it sets on an edge pulse and holds until cleared by a write to address 3.
- Write decode:
  - A write occurs when chipselect && !write_n.
  - Address 2: irqmask <= writedata[WIDTH-1:0].
  - Address 3: clear edgecapture (see Optional Feature).
  - Addresses 0 and 1: writes ignored.
- Simultaneous clear and edge on the same bit in the same cycle: set wins; the bit reads 1 afterwards, so no edge is lost.
- Read mux:
  - readdata is updated every cycle (clk_en=1) from address, independent of chipselect.
  - Address 0 returns data_in, 1 returns 0, 2 returns irqmask, 3 returns edgecapture, all zero-extended to 32 bits.
  - Value is valid the cycle after address is presented.
  - Reads have no side effects.
- IRQ:
  - Registered: irq <= |(src & irqmask), where src = edgecapture (IRQ_TYPE=1) or data_in (IRQ_TYPE=2); IRQ_TYPE=0 forces irq=0.
  - One-cycle lag after src or irqmask changes.
- Latency: in_port change → data_in after SYNC_STAGES cycles → edgecapture set 1 cycle later → irq 1 cycle after that.
- A reset asserted mid-operation clears all state on the next edge; captured edges are lost by design.
- Unused high writedata bits are ignored; out-of-range WIDTH (0 or >32) is an elaboration error.

Optional Feature:
- Macro: PIO_EDGE_IN_BIT_CLEAR_EN.
- Defined: a write to address 3 clears only the bits set in writedata (edgecapture <= edgecapture & ~writedata, write-1-to-clear), so bits can be acknowledged individually.
- Not defined: any write to address 3 clears all edgecapture bits regardless of writedata.
- The set-wins rule applies in both cases.

Decomposition:
- Package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - irq-type constants IRQ_NONE/IRQ_EDGE/IRQ_LEVEL.
- One sub-module, pio_sync_edge: a WIDTH-wide synchroniser chain plus d_prev register, with an edge_pulse output.
- The top level owns the register file, read mux and irq.

Test Plan:
- Reset behaviour: hold reset 3 cycles with in_port=8'hFF → readdata=0, irq=0. Release and read addr 0 → 8'hFF after 2+1 cycles.
- Edge capture: EDGE_TYPE=0. Pulse in_port[3] 0→1→0 (one cycle each, SYNC_STAGES=2) → addr 3 reads 8'h08 and stays 8'h08 after the pulse ends. Falling edge alone → no change.
- Interrupt mask: irqmask=8'h00, edge on bit 3 → irq stays 0. Write irqmask=8'h08 → irq=1 exactly 1 cycle later. Write irqmask=0 → irq=0 one cycle later.
- Clear collision: edgecapture=8'h0C, write addr 3 data 8'h04 in the same cycle as a new edge on bit 2.
  - With BIT_CLEAR_EN: result 8'h0C (set wins on bit 2).
  - Without: result 8'h04.
- Level mode: IRQ_TYPE=2, irqmask=8'h01, in_port[0]=1 → irq asserts SYNC_STAGES+1 cycles later. in_port[0]=0 → irq deasserts with the same lag.
- Width and read latency: WIDTH=1, SYNC_STAGES=0. Address alternated 0/2 each cycle → readdata tracks address with 1-cycle latency; readdata[31:1] is always 0.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the pio_edge_in edge-capturing input PIO: register map,
// edge-type and interrupt-type encodings.
package pio_pkg;

    typedef logic [1:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA    = 2'd0;
    localparam pio_addr_t ADDR_RSVD    = 2'd1;
    localparam pio_addr_t ADDR_IRQMASK = 2'd2;
    localparam pio_addr_t ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    localparam int unsigned IRQ_NONE  = 0;
    localparam int unsigned IRQ_EDGE  = 1;
    localparam int unsigned IRQ_LEVEL = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain (0..3 stages) followed by a previous-sample register
// and per-bit edge detection selected by EDGE_TYPE.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] d_prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign data_in = in_i;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= in_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign data_in = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            d_prev_q <= '0;
        end else begin
            d_prev_q <= data_in;
        end
    end

    assign rise = data_in & ~d_prev_q;
    assign fall = ~data_in & d_prev_q;

    always_comb begin
        edge_o = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_o = rise;
            EDGE_FALL: edge_o = fall;
            default:   edge_o = rise | fall;
        endcase
    end

    assign data_o = data_in;

endmodule

// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO with synchroniser, sticky edge capture, irq mask and registered irq.
// Build option PIO_EDGE_IN_BIT_CLEAR_EN makes edgecapture write-1-to-clear per bit.
module pio_edge_in
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned IRQ_TYPE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pio_edge_in: WIDTH must be in 1..32");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
        $error("pio_edge_in: SYNC_STAGES must be in 0..3");
    end
    if (EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
        $error("pio_edge_in: EDGE_TYPE must be 0, 1 or 2");
    end
    if (IRQ_TYPE > IRQ_LEVEL) begin : g_bad_irq
        $error("pio_edge_in: IRQ_TYPE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    // Bits of writedata above WIDTH are deliberately ignored.
    assign unused_wdata = ^writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk_i   (clk),
        .reset_i (reset),
        .in_i    (in_port),
        .data_o  (data_in),
        .edge_o  (edge_pulse)
    );

    assign wr_en = chipselect && !write_n;

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
`ifdef PIO_EDGE_IN_BIT_CLEAR_EN
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
`else
            edgecap_d = '0;
`endif
        end
        // New edges are OR-ed in after the clear so a colliding edge is never lost.
        edgecap_d = edgecap_d | edge_pulse;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = data_in;
            ADDR_RSVD:    readdata_d = '0;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_comb begin
        irq_d = 1'b0;
        case (IRQ_TYPE)
            IRQ_EDGE:  irq_d = |(edgecap_q & irqmask_q);
            IRQ_LEVEL: irq_d = |(data_in & irqmask_q);
            default:   irq_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed self-checking bench for pio_edge_in: edge-irq, level-irq and 1-bit instances.
module tb_pio_edge_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_main, in_lvl;
    logic        in_w1;
    logic [31:0] rd_main, rd_lvl, rd_w1;
    logic        irq_main, irq_lvl, irq_w1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_main (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(in_main),
        .readdata(rd_main), .irq(irq_main)
    );

    pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(2)) u_lvl (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(in_lvl),
        .readdata(rd_lvl), .irq(irq_lvl)
    );

    pio_edge_in #(.WIDTH(1), .SYNC_STAGES(0), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_w1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(in_w1),
        .readdata(rd_w1), .irq(irq_w1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int sel, input logic [1:0] a, input logic [31:0] d);
        cs        = 3'b000;
        cs[sel]   = 1'b1;
        write_n   = 1'b0;
        address   = a;
        writedata = d;
        tick(1);
        cs        = 3'b000;
        write_n   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_main = 8'hFF; in_lvl = 8'hFF; in_w1 = 1'b1;
        tick(3);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++; $display("FAIL reset_main got rd=%h irq=%b want rd=0 irq=0", rd_main, irq_main);
        end
        checks++;
        if (rd_lvl !== 32'h0 || irq_lvl !== 1'b0 || rd_w1 !== 32'h0 || irq_w1 !== 1'b0) begin
            errors++; $display("FAIL reset_others got lvl=%h/%b w1=%h/%b want 0", rd_lvl, irq_lvl, rd_w1, irq_w1);
        end
        reset = 1'b0; address = 2'd0;
        tick(2);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL sync_latency_early got %h want 00000000", rd_main);
        end
        tick(1);
        checks++;
        if (rd_main !== 32'hFF) begin
            errors++; $display("FAIL sync_latency got %h want 000000ff", rd_main);
        end
        checks++;
        if (rd_w1 !== 32'h1) begin
            errors++; $display("FAIL w1_data got %h want 00000001", rd_w1);
        end
        // Release with inputs high looks like a rising edge on every bit.
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_main !== 32'hFF) begin
            errors++; $display("FAIL release_edges got %h want 000000ff", rd_main);
        end
    endtask

    task automatic test_edge_capture();
        in_main = 8'h00;
        tick(4);
        bus_write(0, 2'd3, 32'hFF);
        tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL edgecap_clear got %h want 00000000", rd_main);
        end
        in_main = 8'h08;
        tick(1);
        in_main = 8'h00;
        tick(5);
        checks++;
        if (rd_main !== 32'h08 || irq_main !== 1'b0) begin
            errors++; $display("FAIL edgecap_set got rd=%h irq=%b want rd=08 irq=0", rd_main, irq_main);
        end
        tick(5);
        checks++;
        if (rd_main !== 32'h08) begin
            errors++; $display("FAIL edgecap_sticky got %h want 00000008", rd_main);
        end
    endtask

    task automatic test_irq_mask();
        bus_write(0, 2'd2, 32'h08);
        checks++;
        if (irq_main !== 1'b0) begin
            errors++; $display("FAIL irq_lag_on got %b want 0", irq_main);
        end
        tick(1);
        checks++;
        if (irq_main !== 1'b1) begin
            errors++; $display("FAIL irq_on got %b want 1", irq_main);
        end
        bus_write(0, 2'd2, 32'h00);
        checks++;
        if (irq_main !== 1'b1) begin
            errors++; $display("FAIL irq_lag_off got %b want 1", irq_main);
        end
        tick(1);
        checks++;
        if (irq_main !== 1'b0) begin
            errors++; $display("FAIL irq_off got %b want 0", irq_main);
        end
    endtask

    task automatic test_fall_only();
        bus_write(0, 2'd3, 32'hFF);
        in_main = 8'h08;
        tick(5);
        bus_write(0, 2'd3, 32'hFF);
        in_main = 8'h00;
        tick(5);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL fall_ignored got %h want 00000000", rd_main);
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] exp;
`ifdef PIO_EDGE_IN_BIT_CLEAR_EN
        exp = 32'h0C;
`else
        exp = 32'h04;
`endif
        in_main = 8'h0C;
        tick(5);
        checks++;
        if (rd_main !== 32'h0C) begin
            errors++; $display("FAIL collide_setup got %h want 0000000c", rd_main);
        end
        in_main = 8'h08;
        tick(5);
        in_main = 8'h0C;
        tick(2);
        bus_write(0, 2'd3, 32'h04);
        tick(1);
        checks++;
        if (rd_main !== exp) begin
            errors++; $display("FAIL clear_collision got %h want %h", rd_main, exp);
        end
        bus_write(0, 2'd0, 32'hFF);
        bus_write(0, 2'd1, 32'hFF);
        address = 2'd2;
        tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL ignored_write_mask got %h want 00000000", rd_main);
        end
        address = 2'd1;
        tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL reserved_read got %h want 00000000", rd_main);
        end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_main !== exp) begin
            errors++; $display("FAIL ignored_write_edgecap got %h want %h", rd_main, exp);
        end
    endtask

    task automatic test_level();
        in_lvl = 8'h00;
        tick(4);
        bus_write(1, 2'd2, 32'h01);
        tick(1);
        checks++;
        if (irq_lvl !== 1'b0) begin
            errors++; $display("FAIL level_idle got %b want 0", irq_lvl);
        end
        in_lvl = 8'h01;
        tick(2);
        checks++;
        if (irq_lvl !== 1'b0) begin
            errors++; $display("FAIL level_on_early got %b want 0", irq_lvl);
        end
        tick(1);
        checks++;
        if (irq_lvl !== 1'b1) begin
            errors++; $display("FAIL level_on got %b want 1", irq_lvl);
        end
        in_lvl = 8'h00;
        tick(2);
        checks++;
        if (irq_lvl !== 1'b1) begin
            errors++; $display("FAIL level_off_early got %b want 1", irq_lvl);
        end
        tick(1);
        checks++;
        if (irq_lvl !== 1'b0) begin
            errors++; $display("FAIL level_off got %b want 0", irq_lvl);
        end
    endtask

    task automatic test_w1_latency();
        logic [31:0] exp, prev_exp;
        bus_write(2, 2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        tick(1);
        checks++;
        if (rd_w1 !== 32'h1) begin
            errors++; $display("FAIL w1_mask got %h want 00000001", rd_w1);
        end
        prev_exp = 32'h1;
        for (int i = 0; i < 6; i++) begin
            in_w1   = (i == 2 || i == 3) ? 1'b1 : 1'b0;
            address = (i % 2 == 0) ? 2'd0 : 2'd2;
            exp     = (i % 2 == 0) ? {31'b0, in_w1} : 32'h1;
            #1;
            checks++;
            if (rd_w1 !== prev_exp) begin
                errors++; $display("FAIL w1_hold[%0d] got %h want %h", i, rd_w1, prev_exp);
            end
            tick(1);
            checks++;
            if (rd_w1 !== exp) begin
                errors++; $display("FAIL w1_track[%0d] got %h want %h", i, rd_w1, exp);
            end
            prev_exp = exp;
        end
    endtask

    task automatic test_mid_reset();
        bus_write(0, 2'd2, 32'hFF);
        tick(1);
        checks++;
        if (irq_main !== 1'b1) begin
            errors++; $display("FAIL pre_reset_irq got %b want 1", irq_main);
        end
        in_main = 8'h00;
        tick(3);
        reset = 1'b1;
        tick(1);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rd=%h irq=%b want 0/0", rd_main, irq_main);
        end
        reset = 1'b0; address = 2'd2;
        tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL mid_reset_mask got %h want 00000000", rd_main);
        end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++; $display("FAIL mid_reset_edgecap got rd=%h irq=%b want 0/0", rd_main, irq_main);
        end
    endtask

    initial begin
        cs = 3'b000; write_n = 1'b1; writedata = 32'h0; address = 2'd0;
        reset = 1'b1; in_main = 8'h00; in_lvl = 8'h00; in_w1 = 1'b0;
        test_reset();
        test_edge_capture();
        test_irq_mask();
        test_fall_only();
        test_clear_collision();
        test_level();
        test_w1_latency();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
